// File: rtl/mult_pkg.sv
// ----------------------------------------------------------------------------
// mult_pkg
// Shared constants, the in-flight tag type and the round-robin index helper
// for the multiplier-sharing arbiter and its round-robin sub-block.
// ----------------------------------------------------------------------------
package mult_pkg;

    localparam int MUL_W       = 64;
    localparam int MUL_LATENCY = 4;

    // One entry of the tag pipeline: does this slot carry a real operation,
    // and which requester owns it. Three id bits cover up to 8 requesters.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } mul_tag_t;

    // Returns (ptr + idx) mod n for ptr < n and idx <= n.
    // Used both to walk the search order from the pointer and to step the
    // pointer one past the granted index.
    function automatic logic [2:0] rr_next(input logic [2:0] ptr,
                                           input logic [2:0] idx,
                                           input int         n);
        logic [3:0] w_sum;
        w_sum = {1'b0, ptr} + {1'b0, idx};
        if (w_sum >= 4'(n))
            w_sum = w_sum - 4'(n);
        return w_sum[2:0];
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// ----------------------------------------------------------------------------
// mult_arbiter_if
// Bundles the requester handshake, the multiplier operand/result path and the
// per-requester response path of mult_arbiter.
//   req_valid/req_a/req_b   : requesters -> arbiter
//   req_ready               : arbiter -> requesters (one-hot grant)
//   mul_a/mul_b             : arbiter -> multiplier (registered operands)
//   mul_result              : multiplier -> arbiter
//   resp_valid/resp_result  : arbiter -> requesters (one-hot pulse + product)
//   inflight                : accepted, not-yet-returned operation count
// modport master: the parent side (requesters plus the multiplier instance).
// modport slave : the arbiter itself.
// ----------------------------------------------------------------------------
interface mult_arbiter_if
    import mult_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = MUL_W,
    parameter int LATENCY = MUL_LATENCY
);
    localparam int CNT_W = $clog2(LATENCY + 2);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_result;
    logic [NREQ-1:0]   resp_valid;
    logic [2*W-1:0]    resp_result;
    logic [CNT_W-1:0]  inflight;

    modport master (
        output req_valid, req_a, req_b, mul_result,
        input  req_ready, mul_a, mul_b, resp_valid, resp_result, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_result,
        output req_ready, mul_a, mul_b, resp_valid, resp_result, inflight
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant over NREQ (2..8) requesters plus the pointer register.
//   clk, rst      : clock, synchronous active-high reset
//   i_req_valid   : request vector
//   o_grant       : one-hot grant, combinational from i_req_valid and pointer
//   o_grant_idx   : index of the granted requester (0 when nothing granted)
//   o_any         : a grant is being given this cycle
// The grant doubles as the ready, so every grant is a completed handshake and
// the pointer advances whenever o_any is high.
// ----------------------------------------------------------------------------
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req_valid,
    output logic [NREQ-1:0] o_grant,
    output logic [2:0]      o_grant_idx,
    output logic            o_any
);

    logic [2:0] r_ptr;
    logic [7:0] w_req_ext;
    logic [2:0] w_cand;

    // Walk the search order backwards so the candidate closest to the
    // pointer is the last one written and therefore wins.
    always_comb begin
        w_req_ext   = 8'(i_req_valid);
        w_cand      = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_cand = rr_next(r_ptr, 3'(k), NREQ);
            if (w_req_ext[w_cand]) begin
                o_grant_idx = w_cand;
                o_any       = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++)
            o_grant[i] = o_any && (o_grant_idx == 3'(i));
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (o_any)
            r_ptr <= rr_next(o_grant_idx, 3'd1, NREQ);
    end

endmodule

// File: rtl/mult_arbiter.sv
// ----------------------------------------------------------------------------
// mult_arbiter
// Shares one fully pipelined multiplier (fixed LATENCY register stages) among
// NREQ requesters: one operand pair accepted per cycle, operands registered
// into the multiplier, a tag pipeline remembers the owner of each product and
// the product is returned to its owner as a one-cycle pulse.
//   clk, rst : clock, synchronous active-high reset (shared with multiplier)
//   bus      : mult_arbiter_if slave view (requests, multiplier path,
//              responses, inflight count)
// ----------------------------------------------------------------------------
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = MUL_W,
    parameter int LATENCY = MUL_LATENCY
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(LATENCY + 2);

    logic [NREQ-1:0]  w_grant;
    logic [2:0]       w_grant_idx;
    logic             w_hs;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    mul_tag_t         r_tag [LATENCY+1];
    mul_tag_t         w_last;
    logic [NREQ-1:0]  w_resp_valid;
    logic [2*W-1:0]   w_resp_result;
    logic [CNT_W-1:0] r_inflight;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (bus.req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_hs)
    );

    assign bus.req_ready = w_grant;

    // AND-OR mux on the one-hot grant; yields zero when nothing is granted,
    // which is exactly the idle operand value.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_a = w_sel_a | (bus.req_a[i*W +: W] & {W{w_grant[i]}});
            w_sel_b = w_sel_b | (bus.req_b[i*W +: W] & {W{w_grant[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else begin
            r_mul_a <= w_sel_a;
            r_mul_b <= w_sel_b;
        end
    end

    assign bus.mul_a = r_mul_a;
    assign bus.mul_b = r_mul_b;

    // Stage 0 lines up with the operand registers; stage LATENCY lines up
    // with the multiplier's registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= LATENCY; s++)
                r_tag[s] <= '0;
        end else begin
            r_tag[0] <= '{valid: w_hs, id: w_grant_idx};
            for (int s = 1; s <= LATENCY; s++)
                r_tag[s] <= r_tag[s-1];
        end
    end

    assign w_last = r_tag[LATENCY];

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            w_resp_valid[i] = w_last.valid && (w_last.id == 3'(i));
        w_resp_result = w_last.valid ? bus.mul_result : '0;
    end

    assign bus.resp_valid  = w_resp_valid;
    assign bus.resp_result = w_resp_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_hs, w_last.valid})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.inflight = r_inflight;

endmodule

// File: tb/tb_mult_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mult_arbiter
// Drives mult_arbiter with directed scenarios and random traffic, feeds it
// from a stand-in pipelined multiplier and compares every cycle against a
// queue-based model of accepted operations.
// ----------------------------------------------------------------------------
module tb_mult_arbiter;
    import mult_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = MUL_W;
    localparam int LAT  = MUL_LATENCY;
    localparam int PW   = 2 * W;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    bit   checking = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_arbiter_if #(.NREQ(NREQ), .W(W), .LATENCY(LAT)) bus ();

    mult_arbiter #(.NREQ(NREQ), .W(W), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: LAT register stages, operands captured on the edge
    // after they are registered by the arbiter.
    logic [PW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) mpipe[s] <= '0;
        end else begin
            mpipe[0] <= PW'(bus.mul_a) * PW'(bus.mul_b);
            for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
        end
    end
    assign bus.mul_result = mpipe[LAT-1];

    // ---------------- reference model ----------------
    // Each accepted operation lives in q with its age in edges since the
    // handshake; it is visible as a response while age == LAT.
    typedef struct {
        int            age;
        int            id;
        logic [PW-1:0] prod;
    } op_t;

    op_t          q[$];
    int           m_ptr   = 0;
    logic [W-1:0] m_mul_a = '0;
    logic [W-1:0] m_mul_b = '0;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    initial forever begin
        int  g;
        op_t o;
        op_t nq[$];
        @(posedge clk);
        g = pick(bus.req_valid, m_ptr);
        if (rst) begin
            q.delete();
            m_ptr   = 0;
            m_mul_a = '0;
            m_mul_b = '0;
        end else begin
            nq.delete();
            foreach (q[k]) begin
                if (q[k].age < LAT) begin
                    o     = q[k];
                    o.age = o.age + 1;
                    nq.push_back(o);
                end
            end
            m_mul_a = '0;
            m_mul_b = '0;
            if (g >= 0) begin
                m_mul_a = bus.req_a[g*W +: W];
                m_mul_b = bus.req_b[g*W +: W];
                o.age   = 0;
                o.id    = g;
                o.prod  = PW'(m_mul_a) * PW'(m_mul_b);
                nq.push_back(o);
                m_ptr = (g + 1) % NREQ;
            end
            q = nq;
        end
    end

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checking) begin
            logic [NREQ-1:0] e_rv;
            logic [NREQ-1:0] e_rd;
            logic [PW-1:0]   e_rr;
            int              g;
            e_rv = '0;
            e_rd = '0;
            e_rr = '0;
            foreach (q[k]) begin
                if (q[k].age == LAT) begin
                    e_rv[q[k].id] = 1'b1;
                    e_rr          = q[k].prod;
                end
            end
            g = pick(bus.req_valid, m_ptr);
            if (g >= 0) e_rd[g] = 1'b1;
            chk("cyc req_ready",   PW'(bus.req_ready),   PW'(e_rd));
            chk("cyc mul_a",       PW'(bus.mul_a),       PW'(m_mul_a));
            chk("cyc mul_b",       PW'(bus.mul_b),       PW'(m_mul_b));
            chk("cyc resp_valid",  PW'(bus.resp_valid),  PW'(e_rv));
            chk("cyc resp_result", bus.resp_result,      e_rr);
            chk("cyc inflight",    PW'(bus.inflight),    PW'(q.size()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.req_valid = '0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_valid[i]    = 1'b1;
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(3))
            0:       return '0;
            1:       return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called 3 time units after an edge; k = further edges until resp_valid,
    // -1 if the budget ran out.
    task automatic wait_resp(output int k, input int budget);
        k = 0;
        while (bus.resp_valid == '0) begin
            if (k >= budget) begin
                k = -1;
                return;
            end
            @(posedge clk);
            #3;
            k++;
        end
    endtask

    task automatic do_single(input string name, input int i, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [PW-1:0] exp_r);
        int k;
        clear_req();
        set_req(i, a, b);
        #1;
        chk({name, " ready"}, PW'(bus.req_ready), PW'(onehot(i)));
        cyc();
        clear_req();
        #2;
        chk({name, " inflight after issue"}, PW'(bus.inflight), PW'(1));
        wait_resp(k, 3 * LAT);
        chk({name, " latency cycles"}, PW'(k + 1), PW'(LAT + 1));
        chk({name, " resp_valid"}, PW'(bus.resp_valid), PW'(onehot(i)));
        chk({name, " resp_result"}, bus.resp_result, exp_r);
        @(posedge clk);
        #3;
        chk({name, " resp_valid after"}, PW'(bus.resp_valid), PW'(0));
        chk({name, " inflight drained"}, PW'(bus.inflight), PW'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        rst           = 1'b1;
        @(posedge clk);
        checking = 1'b1;
        #3;
        chk("reset mul_a",       PW'(bus.mul_a),      PW'(0));
        chk("reset inflight",    PW'(bus.inflight),   PW'(0));
        chk("reset resp_valid",  PW'(bus.resp_valid), PW'(0));
        chk("reset resp_result", bus.resp_result,     PW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention from the first post-reset cycle
        for (int i = 0; i < NREQ; i++) set_req(i, W'(i + 1), W'(1000));
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("contention grant", PW'(bus.req_ready), PW'(onehot(c % NREQ)));
            cyc();
        end
        clear_req();
        #2;
        for (int c = 0; c < 5; c++) begin
            chk("contention resp_valid",  PW'(bus.resp_valid), PW'(onehot(c % NREQ)));
            chk("contention resp_result", bus.resp_result,     PW'((c % NREQ + 1) * 1000));
            @(posedge clk);
            #3;
        end

        do_single("single", 0, W'(15), W'(10), PW'(150));

        // Fairness: 1 and 3 always valid, pointer currently at 1
        cyc();
        set_req(1, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        for (int c = 0; c < 6; c++) begin
            #2;
            chk("fairness grant", PW'(bus.req_ready), PW'((c % 2 == 0) ? 4'b0010 : 4'b1000));
            cyc();
        end
        clear_req();
        repeat (LAT + 2) cyc();

        do_single("max x 1", 0, '1, W'(1),
                  128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        do_single("max x max", 1, '1, '1,
                  128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        do_single("zero x 9999", 2, W'(0), W'(9999), PW'(0));

        // Reset two edges after the last of three issues
        cyc();
        for (int j = 0; j < 3; j++) begin
            clear_req();
            set_req(j, W'(j + 5), W'(3));
            cyc();
        end
        clear_req();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2;
        chk("midreset inflight", PW'(bus.inflight), PW'(0));
        for (int c = 0; c < LAT + 4; c++) begin
            chk("midreset no resp", PW'(bus.resp_valid), PW'(0));
            @(posedge clk);
            #3;
        end
        do_single("post-reset", 3, W'(7), W'(6), PW'(42));

        // Back-to-back from requester 2
        cyc();
        set_req(2, W'(123456789), W'(987654321));
        cyc();
        set_req(2, W'(15), W'(10));
        cyc();
        clear_req();
        #2;
        wait_resp(k, 3 * LAT);
        chk("b2b first edges", PW'(k), PW'(LAT - 1));
        chk("b2b first resp_valid", PW'(bus.resp_valid), PW'(4'b0100));
        chk("b2b first result", bus.resp_result, PW'(128'd121932631112635269));
        @(posedge clk);
        #3;
        chk("b2b second resp_valid", PW'(bus.resp_valid), PW'(4'b0100));
        chk("b2b second result", bus.resp_result, PW'(150));

        // Random traffic with occasional resets
        cyc();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i]) begin
                    if ($urandom_range(3) == 0) bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    set_req(i, rand_op(), rand_op());
                end
            end
            rst = ($urandom_range(99) == 0);
            cyc();
        end
        rst = 1'b0;
        clear_req();
        repeat (LAT + 3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler that shares one `pipelined_multiplier` (64×64→128, fully pipelined, fixed latency) among `NREQ` requesters. It accepts at most one operand pair per cycle and drives the registered operands into the multiplier. A tag pipeline tracks which requester owns each in-flight product, and the block routes each product back to its owner with a one-cycle valid pulse. It sits between the client blocks and the multiplier instance; the multiplier receives the same `clk`/`rst`.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `W`, 64: operand width; product width is 2·W
- `LATENCY`, 4: multiplier register stages (operand capture to registered result)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NREQ: requester i has an operand pair
- `req_ready` out NREQ: one-hot grant; handshake when `req_valid[i] & req_ready[i]`
- `req_a` in NREQ·W: flattened operands A, requester i at bits [i·W +: W]
- `req_b` in NREQ·W: flattened operands B, same layout
- `mul_a` out W: registered operand A to the multiplier
- `mul_b` out W: registered operand B to the multiplier
- `mul_result` in 2·W: multiplier product
- `resp_valid` out NREQ: one-hot pulse; product for requester i is on `resp_result`
- `resp_result` out 2·W: product, shared by all requesters
- `inflight` out clog2(LATENCY+2): count of accepted, not-yet-returned operations

## Operation
- Arbitration is round-robin.
  - Pointer `ptr` is 0 at reset.
  - Grant goes to the first index i, searching ptr, ptr+1, … mod NREQ, with `req_valid[i]`.
  - `req_ready` is combinational from `req_valid` and `ptr`. It is all-zero if no request is valid.
  - On a handshake, `ptr` ← (grant index + 1) mod NREQ. With no handshake, `ptr` holds.
- Issue:
  - On a handshake, `mul_a`/`mul_b` register the granted `req_a`/`req_b` slice.
  - With no handshake, they register 0. Idle operands are deterministic.
- Tag pipeline: LATENCY+1 stages of {valid, id}.
  - Stage 0 loads {handshake, grant index} each edge.
  - Each other stage shifts on every edge. There is no stall.
- Response, from the last stage:
  - `resp_valid[id]` = last-stage valid; all other bits are 0.
  - `resp_result` = `mul_result` when valid, else 0. Driven combinationally.
- Responses have no backpressure. Requesters must sink `resp_valid` pulses unconditionally.
- `inflight` increments on a handshake and decrements on a response valid. If both occur in the same cycle, it holds.
- Throughput is one operation per cycle, sustained by any mix of requesters.

## Timing
- Handshake at edge E0 → `resp_valid` high for exactly the cycle after edge E0+LATENCY. Request-to-response latency is LATENCY+1 cycles.
- Back-to-back handshakes at E0, E1, … produce responses on consecutive cycles, in the same order.
- A single requester holding `req_valid` high with no competitors is granted every cycle.
- All NREQ requesters held valid from reset are granted 0,1,…,NREQ−1,0,… with no gaps.
- Reset: while `rst` is high at an edge:
  - `ptr`, all tag stages, `mul_a`, `mul_b` and `inflight` go to 0.
  - Next cycle: `resp_valid` = 0, `resp_result` = 0. `req_ready` stays combinational on `req_valid`, but no handshake is recorded while `rst` is high.
- Reset mid-operation: every in-flight operation is dropped. No response is emitted for it, including after `rst` falls.
- Requester i must hold `req_a`/`req_b` stable while `req_valid[i]` is high and unacknowledged. Dropping `req_valid` before a grant is legal.

## Structure
- Package `mult_pkg`:
  - constants `MUL_W`=64 and `MUL_LATENCY`=4
  - typedef `mul_tag_t` {logic valid; logic [2:0] id}
  - function `rr_next(ptr, idx, n)`
- Sub-module `rr_arbiter`: combinational grant from `req_valid` + `ptr`, plus the pointer register. It is parameterised by NREQ and reused by other shared-resource controllers.
- `mult_arbiter` holds the issue registers, tag pipeline, response demux and `inflight` counter. The multiplier is instantiated by the parent, not inside this block.

## Test plan
- Single request: requester 0, a=15, b=10 → `resp_valid`=4'b0001 with `resp_result`=150 exactly LATENCY+1 cycles after the handshake; `inflight` goes 1 then back to 0.
- Contention: all four valid from the first post-reset cycle, requester i with a=i+1, b=1000 → grants 0,1,2,3,0; responses 1000, 2000, 3000, 4000 on consecutive cycles, each on the correct `resp_valid` bit.
- Fairness with a gap: requesters 1 and 3 constantly valid → grants strictly alternate 1,3,1,3; requesters 0 and 2 never receive `req_ready`.
- Boundary values:
  - a=2^64−1, b=1 → 0x0000…FFFF_FFFF_FFFF_FFFF
  - a=b=2^64−1 → 0xFFFF…FFFE_0000…0001
  - a=0, b=9999 → 0 with `resp_valid` still pulsed
- Reset mid-flight: issue 3 operations, assert `rst` one cycle two edges later → no `resp_valid` ever appears for them; `inflight`=0; the next request returns normally after LATENCY+1 cycles.
- Back-to-back single requester: requester 2 issues 123456789×987654321 then 15×10 on consecutive cycles → 121932631112635269 then 150 on consecutive cycles, with `resp_valid`=4'b0100 both times.
